// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. One radix-2 step per
//               cycle: shift-add for MUL/MULH/MULHSU/MULHU, restoring
//               division for DIV/DIVU/REM/REMU. Signed operations work on
//               operand magnitudes and fix the sign up when the result is
//               written. Divide-by-zero and signed overflow skip the
//               iteration and produce their result directly.
// Ports       : clk     - sole clock, rising edge
//               reset   - synchronous active-high reset
//               start   - begin an operation (accepted only when idle)
//               flush   - abort any operation in progress
//               Funct3  - RV32M op select
//               SrcA    - rs1 operand (multiplicand / dividend)
//               SrcB    - rs2 operand (multiplier / divisor)
//               busy    - high whenever an operation is in flight
//               done    - one-cycle pulse, Result valid
//               Result  - registered result, held until the next done
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int                c_cnt_w     = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state_q,  w_state_d;
    logic [c_cnt_w-1:0] r_cnt_q,    w_cnt_d;
    logic [2:0]         r_op_q,     w_op_d;
    logic [WIDTH-1:0]   r_hi_q,     w_hi_d;     // product high half / partial remainder
    logic [WIDTH-1:0]   r_lo_q,     w_lo_d;     // multiplier / quotient-dividend shift reg
    logic [WIDTH-1:0]   r_mcand_q,  w_mcand_d;  // multiplicand or divisor magnitude
    logic               r_neg_q,    w_neg_d;    // negate product / quotient
    logic               r_rneg_q,   w_rneg_d;   // negate remainder
    logic [WIDTH-1:0]   r_result_q, w_result_d;

    // ------------------------------------------------------------------
    // Operand decode at acceptance (inputs are only looked at in IDLE)
    // ------------------------------------------------------------------
    logic             w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic             w_div_zero, w_div_ovf;
    logic [WIDTH-1:0] w_bypass_res;

    always_comb begin
        w_a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                     (Funct3 == 3'b100) || (Funct3 == 3'b110);
        w_b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) ||
                     (Funct3 == 3'b110);
        w_a_neg    = w_a_signed && SrcA[WIDTH-1];
        w_b_neg    = w_b_signed && SrcB[WIDTH-1];
        // The most-negative value's magnitude still fits unsigned WIDTH bits.
        w_mag_a    = w_a_neg ? -SrcA : SrcA;
        w_mag_b    = w_b_neg ? -SrcB : SrcB;
        w_div_zero = Funct3[2] && (SrcB == '0);
        w_div_ovf  = ((Funct3 == 3'b100) || (Funct3 == 3'b110)) &&
                     (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
        if (w_div_zero) begin
            w_bypass_res = Funct3[1] ? SrcA : '1;
        end else begin
            w_bypass_res = Funct3[1] ? '0 : SrcA;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_step_hi, w_step_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]   w_quo, w_rem, w_final;

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier bit is
        // set, then shift {carry, hi, lo} right by one.
        w_mul_sum  = {1'b0, r_hi_q} + (r_lo_q[0] ? {1'b0, r_mcand_q} : '0);
        // Restoring divide: shift next dividend bit into the remainder and
        // subtract the divisor if it fits. The difference is below the
        // divisor whenever it is kept, so WIDTH bits are enough.
        w_div_sh   = {r_hi_q, r_lo_q[WIDTH-1]};
        w_div_ge   = (w_div_sh >= {1'b0, r_mcand_q});
        w_div_diff = w_div_sh[WIDTH-1:0] - r_mcand_q;

        if (r_op_q[2]) begin
            w_step_hi = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
            w_step_lo = {r_lo_q[WIDTH-2:0], w_div_ge};
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_lo_q[WIDTH-1:1]};
        end

        w_prod   = {w_step_hi, w_step_lo};
        w_prod_s = r_neg_q  ? -w_prod    : w_prod;
        w_quo    = r_neg_q  ? -w_step_lo : w_step_lo;
        w_rem    = r_rneg_q ? -w_step_hi : w_step_hi;

        if (r_op_q[2]) begin
            w_final = r_op_q[1] ? w_rem : w_quo;
        end else if (r_op_q[1:0] == 2'b00) begin
            w_final = w_prod_s[WIDTH-1:0];
        end else begin
            w_final = w_prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_op_d     = r_op_q;
        w_hi_d     = r_hi_q;
        w_lo_d     = r_lo_q;
        w_mcand_d  = r_mcand_q;
        w_neg_d    = r_neg_q;
        w_rneg_d   = r_rneg_q;
        w_result_d = r_result_q;

        case (r_state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    w_op_d   = Funct3;
                    w_neg_d  = w_a_neg ^ w_b_neg;
                    w_rneg_d = w_a_neg;
                    w_cnt_d  = '0;
                    if (w_div_zero || w_div_ovf) begin
                        w_result_d = w_bypass_res;
                        w_state_d  = S_DONE;
                    end else begin
                        w_hi_d    = '0;
                        w_lo_d    = Funct3[2] ? w_mag_a : w_mag_b;
                        w_mcand_d = Funct3[2] ? w_mag_b : w_mag_a;
                        w_state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_hi_d  = w_step_hi;
                    w_lo_d  = w_step_lo;
                    w_cnt_d = r_cnt_q + c_cnt_one;
                    if (r_cnt_q == c_last_iter) begin
                        w_result_d = w_final;
                        w_state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_cnt_q    <= '0;
            r_op_q     <= '0;
            r_hi_q     <= '0;
            r_lo_q     <= '0;
            r_mcand_q  <= '0;
            r_neg_q    <= 1'b0;
            r_rneg_q   <= 1'b0;
            r_result_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_op_q     <= w_op_d;
            r_hi_q     <= w_hi_d;
            r_lo_q     <= w_lo_d;
            r_mcand_q  <= w_mcand_d;
            r_neg_q    <= w_neg_d;
            r_rneg_q   <= w_rneg_d;
            r_result_q <= w_result_d;
        end
    end

    assign busy   = (r_state_q != S_IDLE);
    assign done   = (r_state_q == S_DONE);
    assign Result = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (WIDTH=32).
//               Expected results and latencies are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [2:0] c_mul    = 3'b000;
    localparam logic [2:0] c_mulh   = 3'b001;
    localparam logic [2:0] c_mulhsu = 3'b010;
    localparam logic [2:0] c_mulhu  = 3'b011;
    localparam logic [2:0] c_div    = 3'b100;
    localparam logic [2:0] c_divu   = 3'b101;
    localparam logic [2:0] c_rem    = 3'b110;
    localparam logic [2:0] c_remu   = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic [2:0]   Funct3;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] last_res;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Drives one operation, scrambles
    // the operands after acceptance, pokes start once while busy, and checks
    // latency (negedges from acceptance to done), busy, Result and hold.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int exp_lat);
        int   n;
        logic seen;
        logic busy_ok;
        start  = 1'b1;
        Funct3 = op;
        SrcA   = a;
        SrcB   = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        Funct3 = 3'($urandom);
        SrcA   = $urandom;
        SrcB   = $urandom;
        n       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (!busy) busy_ok = 1'b0;
            if (done) seen = 1'b1;
            if (n == 3) begin
                start  = 1'b1;
                Funct3 = 3'($urandom);
                SrcA   = $urandom;
                SrcB   = $urandom;
            end else if (n == 4) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, W'(seen), W'(1));
        check({tag, " latency"}, W'(n), W'(exp_lat));
        check({tag, " result"}, Result, exp_res);
        check({tag, " busy_during"}, W'(busy_ok), W'(1));
        @(negedge clk);
        check({tag, " busy_after"}, W'(busy), W'(0));
        check({tag, " done_pulse"}, W'(done), W'(0));
        check({tag, " result_hold"}, Result, exp_res);
        last_res = exp_res;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done_seen;
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        Funct3 = '0;
        SrcA   = '0;
        SrcB   = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset result", Result, W'(0));
        reset = 1'b0;
        @(negedge clk);

        // Multiply family
        run_op("mul",      c_mul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",     c_mulh,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",    c_mulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu",   c_mulhsu, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("mul_big",  c_mul,    32'h0001_0001,  32'h0001_0001, 32'h0002_0001, 33);

        // Divide family
        run_op("div",      c_div,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",      c_rem,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",     c_divu,   32'd100,        32'd7,         32'd14,        33);
        run_op("remu",     c_remu,   32'd100,        32'd7,         32'd2,         33);
        run_op("div_nd",   c_div,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_nd",   c_rem,    32'd7,          32'hFFFF_FFFE, 32'd1,         33);

        // Bypass cases
        run_op("divu_z",   c_divu,   32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_z",    c_rem,    32'h0000_1234,  32'd0,         32'h0000_1234, 1);
        run_op("div_ovf",  c_div,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  c_rem,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Flush in CALC cycle 10
        start  = 1'b1;
        Funct3 = c_divu;
        SrcA   = 32'd1000;
        SrcB   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush busy", W'(busy), W'(0));
        check("flush done", W'(done | done_seen), W'(0));
        check("flush result", Result, last_res);
        run_op("post_flush", c_divu, 32'd1000, 32'd3, 32'd333, 33);

        // Flush in IDLE blocks a coincident start
        start  = 1'b1;
        flush  = 1'b1;
        Funct3 = c_divu;
        SrcA   = 32'd50;
        SrcB   = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("idle_flush busy", W'(busy), W'(0));
        check("idle_flush done", W'(done), W'(0));
        check("idle_flush result", Result, last_res);

        // Reset in CALC cycle 5
        start  = 1'b1;
        Funct3 = c_mulhu;
        SrcA   = 32'hFFFF_FFFF;
        SrcB   = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset busy", W'(busy), W'(0));
        check("midreset done", W'(done), W'(0));
        check("midreset result", Result, W'(0));
        last_res = '0;

        run_op("post_reset", c_mulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33);
        run_op("post_reset_mul", c_mul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
